// File: rtl/tns_lane_scheduler_if.sv
// Request, link and encoder-side signals of the TNS lane scheduler.
// The scheduler uses the slave modport; the driving environment uses master.
interface tns_lane_scheduler_if #(
  parameter int unsigned DATA_W = 10
);
  logic              a_valid;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              link_ready;
  logic              resync;
  logic [DATA_W-1:0] enc_datain;
  logic [1:0]        code_tag;
  logic              in_sync;
  logic [15:0]       word_count;

  modport master (
    output a_valid, a_data, b_valid, b_data, link_ready, resync,
    input  a_ready, b_ready, enc_datain, code_tag, in_sync, word_count
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, link_ready, resync,
    output a_ready, b_ready, enc_datain, code_tag, in_sync, word_count
  );
endinterface

// File: rtl/tns_lane_scheduler.sv
// Two-requester round-robin scheduler feeding a TNS encoder, with sync-burst insertion.
// enc_datain is combinational; code_tag lags one cycle to line up with the encoder register.
module tns_lane_scheduler #(
  parameter int unsigned       DATA_W    = 10,
  parameter int unsigned       SYNC_LEN  = 8,
  parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(1),
  parameter logic [DATA_W-1:0] IDLE_WORD = '0
) (
  input logic                 clock,
  input logic                 reset,
  tns_lane_scheduler_if.slave bus
);

  typedef enum logic [0:0] {StSync, StRun} state_e;

  localparam logic [7:0] LastCnt = 8'(SYNC_LEN - 1);
  localparam logic [1:0] TagIdle = 2'b00;
  localparam logic [1:0] TagA    = 2'b01;
  localparam logic [1:0] TagB    = 2'b10;
  localparam logic [1:0] TagSync = 2'b11;

  state_e      state_q, state_d;
  logic [7:0]  sync_cnt_q, sync_cnt_d;
  logic        ptr_q, ptr_d;  // 0 = A has priority, 1 = B
  logic [1:0]  code_tag_q, code_tag_d;
  logic [15:0] word_count_q, word_count_d;

  logic              grant_a;
  logic              grant_b;
  logic [DATA_W-1:0] enc_word;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StSync;
      sync_cnt_q   <= '0;
      ptr_q        <= 1'b0;
      code_tag_q   <= TagIdle;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      sync_cnt_q   <= sync_cnt_d;
      ptr_q        <= ptr_d;
      code_tag_q   <= code_tag_d;
      word_count_q <= word_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    ptr_d      = ptr_q;
    code_tag_d = TagIdle;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    enc_word   = IDLE_WORD;

    unique case (state_q)
      StSync: begin
        enc_word   = SYNC_WORD;
        code_tag_d = TagSync;
        // resync wins over the terminal count so the whole burst restarts
        if (bus.resync) begin
          sync_cnt_d = '0;
        end else if (sync_cnt_q == LastCnt) begin
          sync_cnt_d = '0;
          state_d    = StRun;
        end else begin
          sync_cnt_d = sync_cnt_q + 8'd1;
        end
      end
      StRun: begin
        if (bus.link_ready) begin
          if (bus.a_valid && (!bus.b_valid || !ptr_q)) begin
            grant_a = 1'b1;
          end else if (bus.b_valid) begin
            grant_b = 1'b1;
          end
        end
        if (grant_a) begin
          enc_word   = bus.a_data;
          code_tag_d = TagA;
          ptr_d      = 1'b1;
        end else if (grant_b) begin
          enc_word   = bus.b_data;
          code_tag_d = TagB;
          ptr_d      = 1'b0;
        end
        if (bus.resync) begin
          state_d    = StSync;
          sync_cnt_d = '0;
        end
      end
      default: begin
        state_d    = StSync;
        sync_cnt_d = '0;
      end
    endcase
  end

  assign word_count_d = word_count_q + 16'((grant_a || grant_b) ? 1 : 0);

  assign bus.a_ready    = grant_a;
  assign bus.b_ready    = grant_b;
  assign bus.enc_datain = enc_word;
  assign bus.code_tag   = code_tag_q;
  assign bus.in_sync    = (state_q == StSync);
  assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_tns_lane_scheduler.sv
// Randomised and directed bench for tns_lane_scheduler against a cycle-level behavioural model.
module tb_tns_lane_scheduler;

  localparam int unsigned DW       = 10;
  localparam int unsigned SYNC_LEN = 8;
  localparam logic [DW-1:0] SYNC_WORD = 10'd1;
  localparam logic [DW-1:0] IDLE_WORD = 10'd0;

  logic clock;
  logic reset;

  tns_lane_scheduler_if #(.DATA_W(DW)) bus ();

  tns_lane_scheduler #(
    .DATA_W   (DW),
    .SYNC_LEN (SYNC_LEN),
    .SYNC_WORD(SYNC_WORD),
    .IDLE_WORD(IDLE_WORD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // {a_ready, b_ready, in_sync, enc_datain, code_tag, word_count}
  wire  [30:0] obs_vec = {bus.a_ready, bus.b_ready, bus.in_sync, bus.enc_datain,
                          bus.code_tag, bus.word_count};
  logic [30:0] exp_vec;
  logic [30:0] rst_obs;
  logic [30:0] rst_exp;

  // Behavioural model: sync words still to send, priority owner, transfer tally, pending tag.
  bit          m_sync;
  int          m_left;
  bit          m_ptr_b;
  logic [15:0] m_count;
  logic [1:0]  m_tag;

  task automatic do_reset();
    @(negedge clock);
    reset          = 1'b1;
    bus.a_valid    = 1'b1;
    bus.b_valid    = 1'b1;
    bus.a_data     = DW'($urandom);
    bus.b_data     = DW'($urandom);
    bus.link_ready = 1'b1;
    bus.resync     = 1'b0;
    #1;
    rst_obs = obs_vec;
    rst_exp = {1'b0, 1'b0, 1'b1, SYNC_WORD, 2'b00, 16'h0000};
    @(posedge clock);
    #2;
    reset   = 1'b0;
    m_sync  = 1'b1;
    m_left  = SYNC_LEN;
    m_ptr_b = 1'b0;
    m_count = '0;
    m_tag   = 2'b00;
  endtask

  // Drives one cycle's inputs, then derives that cycle's expectations and advances the model.
  task automatic apply(input bit av, input logic [DW-1:0] ad, input bit bv,
                       input logic [DW-1:0] bd, input bit lr, input bit rs);
    bit wa, wb;
    logic [DW-1:0] enc;
    logic [1:0] sel;
    @(negedge clock);
    bus.a_valid    = av;
    bus.a_data     = ad;
    bus.b_valid    = bv;
    bus.b_data     = bd;
    bus.link_ready = lr;
    bus.resync     = rs;
    #1;
    wa = 1'b0;
    wb = 1'b0;
    if (m_sync) begin
      enc = SYNC_WORD;
      sel = 2'b11;
    end else begin
      if (lr && av && bv) begin
        wa = !m_ptr_b;
        wb = m_ptr_b;
      end else if (lr) begin
        wa = av;
        wb = bv;
      end
      enc = wa ? ad : (wb ? bd : IDLE_WORD);
      sel = {wb, wa};
    end
    exp_vec = {wa, wb, m_sync, enc, m_tag, m_count};
    m_tag   = sel;
    if (m_sync) begin
      if (rs) m_left = SYNC_LEN;
      else begin
        m_left--;
        if (m_left == 0) m_sync = 1'b0;
      end
    end else begin
      if (wa || wb) begin
        m_count++;
        m_ptr_b = wa;
      end
      if (rs) begin
        m_sync = 1'b1;
        m_left = SYNC_LEN;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (rst_obs !== rst_exp) begin
      n_fail++;
      $display("FAIL reset: got %h expected %h", rst_obs, rst_exp);
    end
  endtask

  task automatic test_sync_burst();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      apply(1'b0, DW'($urandom), 1'b0, DW'($urandom), 1'b1, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec || bus.in_sync !== (i < SYNC_LEN)) begin
        n_fail++;
        $display("FAIL sync_burst cyc %0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_alternate();
    do_reset();
    for (int i = 0; i < SYNC_LEN + 6; i++) begin
      bit run;
      run = (i >= SYNC_LEN);
      apply(run, DW'($urandom), run, DW'($urandom), 1'b1, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec ||
          (run && bus.a_ready !== ((i - SYNC_LEN) % 2 == 0)) ||
          (i == SYNC_LEN + 4 && bus.word_count !== 16'd4)) begin
        n_fail++;
        $display("FAIL alternate cyc %0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_only_b();
    bit exp_a[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < SYNC_LEN + 5; i++) begin
      int k;
      k = i - SYNC_LEN;
      apply(k >= 3, DW'($urandom), i >= SYNC_LEN, DW'($urandom), 1'b1, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec ||
          (k >= 0 && (bus.a_ready !== exp_a[k] || bus.b_ready !== !exp_a[k]))) begin
        n_fail++;
        $display("FAIL only_b cyc %0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_link_stall();
    bit lr_pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bit exp_a[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    bit exp_b[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < SYNC_LEN + 5; i++) begin
      int k;
      k = i - SYNC_LEN;
      if (k < 0) apply(1'b1, DW'($urandom), 1'b1, DW'($urandom), 1'b1, 1'b0);
      else apply(1'b1, DW'($urandom), 1'b1, DW'($urandom), lr_pat[k], 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec ||
          (k >= 0 && (bus.a_ready !== exp_a[k] || bus.b_ready !== exp_b[k])) ||
          (k == 1 && bus.enc_datain !== IDLE_WORD) ||
          (k == 2 && bus.word_count !== 16'd1)) begin
        n_fail++;
        $display("FAIL link_stall cyc %0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_resync();
    do_reset();
    // A grant with resync, a restart at sync_cnt 5, then 8 more sync cycles before run
    for (int i = 0; i < SYNC_LEN + 18; i++) begin
      int k;
      bit rs;
      k  = i - SYNC_LEN;
      rs = (k == 0) || (k == 6);
      apply(1'b1, DW'($urandom), 1'b0, DW'($urandom), 1'b1, rs);
      n_cmp++;
      if (obs_vec !== exp_vec ||
          (k == 0 && bus.a_ready !== 1'b1) ||
          (k == 1 && bus.code_tag !== 2'b01) ||
          (k >= 1 && bus.in_sync !== (k <= 14))) begin
        n_fail++;
        $display("FAIL resync cyc %0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
    // resync on the terminal count keeps the FSM in sync for a full new burst
    do_reset();
    for (int i = 0; i < 2 * SYNC_LEN + 2; i++) begin
      apply(1'b1, DW'($urandom), 1'b1, DW'($urandom), 1'b1, i == SYNC_LEN - 1);
      n_cmp++;
      if (obs_vec !== exp_vec || bus.in_sync !== (i < 2 * SYNC_LEN)) begin
        n_fail++;
        $display("FAIL resync_term cyc %0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
        n_cmp++;
        if (rst_obs !== rst_exp) begin
          n_fail++;
          $display("FAIL random_reset cyc %0d: got %h expected %h", i, rst_obs, rst_exp);
        end
      end
      apply($urandom_range(99) < 60, DW'($urandom), $urandom_range(99) < 60, DW'($urandom),
            $urandom_range(99) < 80, $urandom_range(99) < 4);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < SYNC_LEN; i++) begin
      apply(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 65538; i++) begin
      apply(1'b1, DW'($urandom), 1'b1, DW'($urandom), 1'b1, 1'b0);
      if (i >= 65534) begin
        n_cmp++;
        if (obs_vec !== exp_vec || bus.word_count !== 16'(i)) begin
          n_fail++;
          $display("FAIL wrap xfer %0d: count %h expected %h (vec %h vs %h)", i,
                   bus.word_count, 16'(i), obs_vec, exp_vec);
        end
      end
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.a_valid    = 1'b0;
    bus.a_data     = '0;
    bus.b_valid    = 1'b0;
    bus.b_data     = '0;
    bus.link_ready = 1'b0;
    bus.resync     = 1'b0;
    test_reset();
    test_sync_burst();
    test_alternate();
    test_only_b();
    test_link_stall();
    test_resync();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
